spring_motor_ctrl: RTL
======================

// Module: spring_motor_ctrl
// PURPOSE
//  Downstream dispense stage of vending_machine. It consumes spring_motor_en
//  (used as motor_req) and the tray/product selection.
//  - Runs the selected spiral motor until the drop sensor confirms a product
//    fell, or until a jam timeout expires.
//  - Tracks per-slot stock and reports one-cycle success or failure pulses
//    back to the vend flow.
// PARAMETERS
//  NUM_TRAYS      6    valid tray_sel range is 0..NUM_TRAYS-1
//  NUM_SLOTS      6    valid product_sel range is 0..NUM_SLOTS-1
//  STOCK_W        4    stock counter width; maximum stock is 2**STOCK_W-1
//  INIT_STOCK     5    per-slot stock loaded at reset
//  SPIN_TIMEOUT   200  maximum SPIN cycles before a jam is declared
//  SETTLE_CYCLES  4    motor-off wait after drop, before vend_ok
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        synchronous active-low reset
//  tray_sel     in   3        tray index, sampled on request
//  product_sel  in   3        slot index, sampled on request
//  motor_req    in   1        level from vending_machine.spring_motor_en; rising edge starts a vend
//  drop_sensor  in   1        asynchronous IR beam, high = product falling
//  restock_en   in   1        1-cycle strobe: add restock_qty to the selected slot
//  restock_qty  in   STOCK_W  quantity to add
//  motor_on     out  1        drive for the selected spiral motor
//  busy         out  1        high in every state except IDLE
//  vend_ok      out  1        1-cycle pulse: product delivered
//  vend_fail    out  1        1-cycle pulse: vend aborted
//  fault_code   out  2        0 none, 1 invalid selection, 2 slot empty, 3 jam/timeout
//  stock_level  out  STOCK_W  registered stock of {tray_sel,product_sel}; 1-cycle latency; 0 if selection invalid
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - motor_on, busy, vend_ok and vend_fail go to 0; fault_code goes to 0; state goes to IDLE.
//  - Every stock counter reloads INIT_STOCK; sensor synchroniser clears; timer clears.
//  - Reset mid-SPIN: motor_on is 0 after that same edge, and the in-flight vend is lost without a pulse.
//  Request path:
//  - motor_req is registered; a request is motor_req=1 with its previous sample 0.
//  - A held-high motor_req does not retrigger. Edges seen while busy are ignored.
//  - drop_sensor passes through a 2-flop synchroniser (ds_s) before use.
//  FSM states: IDLE, CHECK, SPIN, SETTLE, DONE, FAULT.
//  - IDLE: on a request, latch tray/product and go to CHECK. fault_code clears to 0 on request acceptance.
//  - CHECK, one cycle, checks in this priority order:
//    - tray>=NUM_TRAYS or product>=NUM_SLOTS: go to FAULT with code 1.
//    - stock==0: go to FAULT with code 2.
//    - otherwise: go to SPIN and clear the timer.
//  - SPIN: motor_on=1 and the timer increments each cycle.
//    - ds_s=1: go to SETTLE.
//    - timer==SPIN_TIMEOUT-1 with ds_s=0: jam, go to FAULT with code 3.
//    - ds_s=1 in the same cycle as the timeout: the drop wins.
//  - SETTLE: motor_on=0; wait SETTLE_CYCLES cycles, then go to DONE.
//  - DONE, one cycle: vend_ok=1, decrement the latched slot's stock by 1, go to IDLE.
//  - FAULT, one cycle: vend_fail=1, go to IDLE. fault_code holds until the next accepted request.
//  Latency:
//  - motor_on rises 3 edges after the first edge that samples motor_req high
//    (edge-detect register, request acceptance, CHECK).
//  - motor_on falls 3 edges after drop_sensor first goes high.
//  Stock arithmetic:
//  - A decrement never underflows, because CHECK guarantees stock>=1.
//  - Restock saturates at 2**STOCK_W-1.
//  - restock_en is applied only in IDLE with no request accepted that cycle; otherwise it is dropped.
//  - restock_en with an invalid selection is ignored.
// CONFIGURATION
//  SPRING_RETRY_EN defined:
//  - The first timeout in a vend does not fault. Instead, motor_on drops for 2 cycles,
//    the timer clears and SPIN repeats once.
//  - A second timeout goes to FAULT with code 3.
//  - A drop during the retry completes normally with vend_ok.
//  SPRING_RETRY_EN undefined:
//  - The first timeout goes straight to FAULT with code 3; no retry logic is present.
// TESTING
//  1. Reset, then tray=1, product=2, rise motor_req; drop_sensor=1 after 20 cycles of motor_on
//     -> motor_on for ~22 cycles, vend_ok pulses once, stock_level for 1/2 goes 5 -> 4.
//  2. tray=6, product=1, rise motor_req
//     -> motor_on never asserts, vend_fail pulses, fault_code=1, stock unchanged.
//  3. Vend slot 0/0 five times to drain it, then request it again
//     -> sixth request gives vend_fail with fault_code=2, motor_on stays 0.
//  4. Request with no drop_sensor
//     -> motor_on high for exactly 200 cycles, then vend_fail, fault_code=3.
//     With SPRING_RETRY_EN: 200 on, 2 off, 200 on, then vend_fail.
//  5. Pulse rst_n low during SPIN
//     -> motor_on=0 after that edge, busy=0, no vend_ok or vend_fail, all stock back to 5.
//  6. Hold motor_req high for 500 cycles across a complete vend
//     -> exactly one vend_ok.
//     Then restock 0/0 by 15 from stock 4 -> stock_level saturates at 15.

Source files
------------

// File: rtl/spring_motor_ctrl.sv
// Spiral-motor dispense stage: runs the selected motor until the drop beam confirms a product, tracks per-slot stock.
// Optional build macro SPRING_RETRY_EN: the first jam timeout pauses the motor and spins once more before faulting.
module spring_motor_ctrl #(
    parameter int NUM_TRAYS     = 6,
    parameter int NUM_SLOTS     = 6,
    parameter int STOCK_W       = 4,
    parameter int INIT_STOCK    = 5,
    parameter int SPIN_TIMEOUT  = 200,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         tray_sel,
    input  logic [2:0]         product_sel,
    input  logic               motor_req,
    input  logic               drop_sensor,
    input  logic               restock_en,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic               motor_on,
    output logic               busy,
    output logic               vend_ok,
    output logic               vend_fail,
    output logic [1:0]         fault_code,
    output logic [STOCK_W-1:0] stock_level
);

    localparam int NUM_CELLS = NUM_TRAYS * NUM_SLOTS;
    localparam int IDX_W     = $clog2(NUM_CELLS);
    localparam int TIMER_W   = $clog2(SPIN_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST   = TIMER_W'(SPIN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [STOCK_W-1:0] STOCK_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SPIN,
        SETTLE,
        DONE,
        FAULT
`ifdef SPRING_RETRY_EN
        , PAUSE
`endif
    } state_t;

    function automatic logic sel_valid(input logic [2:0] t, input logic [2:0] p);
        return (int'(t) < NUM_TRAYS) && (int'(p) < NUM_SLOTS);
    endfunction

    function automatic logic [IDX_W-1:0] cell_of(input logic [2:0] t, input logic [2:0] p);
        return IDX_W'(int'(t) * NUM_SLOTS + int'(p));
    endfunction

    state_t               state, state_next;
    logic                 req_q, req_prev, request;
    logic                 ds_meta, ds_s;
    logic [2:0]           tray_q, prod_q;
    logic [IDX_W-1:0]     cell_q, cell_in;
    logic                 sel_ok_q, sel_ok_in;
    logic [TIMER_W-1:0]   timer;
    logic                 timer_clr, accept, fault_set;
    logic [1:0]           fault_val;
    logic [STOCK_W-1:0]   stock [NUM_CELLS];
    logic [STOCK_W:0]     restock_sum;
    logic [STOCK_W-1:0]   restock_val;
    logic                 restock_apply;
`ifdef SPRING_RETRY_EN
    logic                 retry_used, retry_take;
`endif

    assign request   = req_q & ~req_prev;
    assign cell_q    = cell_of(tray_q, prod_q);
    assign sel_ok_q  = sel_valid(tray_q, prod_q);
    assign cell_in   = cell_of(tray_sel, product_sel);
    assign sel_ok_in = sel_valid(tray_sel, product_sel);

    // Request edge detect and drop-beam synchroniser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            req_prev <= 1'b0;
            ds_meta  <= 1'b0;
            ds_s     <= 1'b0;
        end else begin
            req_q    <= motor_req;
            req_prev <= req_q;
            ds_meta  <= drop_sensor;
            ds_s     <= ds_meta;
        end
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        accept     = 1'b0;
        fault_set  = 1'b0;
        fault_val  = 2'd0;
        motor_on   = 1'b0;
        vend_ok    = 1'b0;
        vend_fail  = 1'b0;
        busy       = (state != IDLE);
`ifdef SPRING_RETRY_EN
        retry_take = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (request) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!sel_ok_q) begin
                    fault_set  = 1'b1;
                    fault_val  = 2'd1;
                    state_next = FAULT;
                end else if (stock[cell_q] == '0) begin
                    fault_set  = 1'b1;
                    fault_val  = 2'd2;
                    state_next = FAULT;
                end else begin
                    timer_clr  = 1'b1;
                    state_next = SPIN;
                end
            end
            SPIN: begin
                motor_on = 1'b1;
                // A drop seen on the timeout cycle still counts as a delivery.
                if (ds_s) begin
                    timer_clr  = 1'b1;
                    state_next = SETTLE;
                end else if (timer == SPIN_LAST) begin
`ifdef SPRING_RETRY_EN
                    if (!retry_used) begin
                        retry_take = 1'b1;
                        timer_clr  = 1'b1;
                        state_next = PAUSE;
                    end else begin
                        fault_set  = 1'b1;
                        fault_val  = 2'd3;
                        state_next = FAULT;
                    end
`else
                    fault_set  = 1'b1;
                    fault_val  = 2'd3;
                    state_next = FAULT;
`endif
                end
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) state_next = DONE;
            end
            DONE: begin
                vend_ok    = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                vend_fail  = 1'b1;
                state_next = IDLE;
            end
`ifdef SPRING_RETRY_EN
            PAUSE: begin
                if (timer == TIMER_W'(1)) begin
                    timer_clr  = 1'b1;
                    state_next = SPIN;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            tray_q     <= '0;
            prod_q     <= '0;
            fault_code <= 2'd0;
        end else begin
            state <= state_next;
            timer <= timer_clr ? '0 : timer + 1'b1;
            if (accept) begin
                tray_q     <= tray_sel;
                prod_q     <= product_sel;
                fault_code <= 2'd0;
            end else if (fault_set) begin
                fault_code <= fault_val;
            end
        end
    end

`ifdef SPRING_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          retry_used <= 1'b0;
        else if (accept)     retry_used <= 1'b0;
        else if (retry_take) retry_used <= 1'b1;
    end
`endif

    // Restock only lands while idle and no vend is starting on the same edge.
    always_comb begin
        restock_sum   = {1'b0, stock[cell_in]} + {1'b0, restock_qty};
        restock_val   = restock_sum[STOCK_W] ? STOCK_MAX : restock_sum[STOCK_W-1:0];
        restock_apply = restock_en && sel_ok_in && (state == IDLE) && !accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
            stock_level <= '0;
        end else begin
            if (state == DONE) begin
                stock[cell_q] <= stock[cell_q] - 1'b1;
            end else if (restock_apply) begin
                stock[cell_in] <= restock_val;
            end
            stock_level <= sel_ok_in ? stock[cell_in] : '0;
        end
    end

endmodule
